// File: rtl/pol_req_generator.sv
// Turns a packed {pol, row, col} event word into a one-hot polarity request for the
// arbiter, holding it until granted or dropping it after TIMEOUT request cycles.
module pol_req_generator #(
    parameter int ROW_W    = 4,
    parameter int COL_W    = 4,
    parameter int POLARITY = 2,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     evt_valid_i,
    output logic                     evt_ready_o,
    input  logic [ROW_W+COL_W:0]     evt_data_i,
    output logic [POLARITY-1:0]      req_o,
    output logic [ROW_W-1:0]         row_o,
    output logic [COL_W-1:0]         col_o,
    input  logic                     gnt_i,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    // state   | meaning
    // IDLE    | ready for a new event word, no request driven
    // REQ     | one-hot request driven, waiting for grant or timeout
    // RELEASE | grant seen, waiting for the arbiter to drop gnt_i
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]       T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [POLARITY-1:0] REQ_ON  = POLARITY'(2);
    localparam logic [POLARITY-1:0] REQ_OFF = POLARITY'(1);

    state_t             state_q, state_d;
    logic               pol_q, pol_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [TW-1:0]      wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               armed_q, armed_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            pol_q     <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pol_q     <= pol_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            armed_q   <= armed_d;
        end
    end

    // armed_q keeps ready low until the first clock after reset release
    always_comb begin
        state_d   = state_q;
        pol_d     = pol_q;
        row_d     = row_q;
        col_d     = col_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        drop_d    = drop_q;
        armed_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (armed_q && evt_valid_i) begin
                    pol_d   = evt_data_i[ROW_W+COL_W];
                    row_d   = evt_data_i[ROW_W+COL_W-1:COL_W];
                    col_d   = evt_data_i[COL_W-1:0];
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // a grant on the last wait cycle takes priority over the drop
                if (gnt_i) begin
                    state_d = RELEASE;
                end else if (wait_q == T_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    if (drop_q != {CNT_W{1'b1}}) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            RELEASE: begin
                if (!gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign evt_ready_o = armed_q && (state_q == IDLE);
    assign req_o       = (state_q == REQ) ? (pol_q ? REQ_ON : REQ_OFF) : '0;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign busy_o      = (state_q != IDLE);
    assign timeout_o   = timeout_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_pol_req_generator.sv
// Directed and randomized checks of pol_req_generator against a per-transaction
// model: each event is either granted after a chosen delay or dropped after TIMEOUT.
module tb_pol_req_generator;

    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;
    localparam int MAXD    = (1 << CNT_W) - 1;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   evt_valid_i;
    logic                   evt_ready_o;
    logic [ROW_W+COL_W:0]   evt_data_i;
    logic [1:0]             req_o;
    logic [ROW_W-1:0]       row_o;
    logic [COL_W-1:0]       col_o;
    logic                   gnt_i;
    logic                   busy_o;
    logic                   timeout_o;
    logic [CNT_W-1:0]       drop_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;
    int drop_model = 0;

    pol_req_generator #(
        .ROW_W(ROW_W), .COL_W(COL_W), .POLARITY(2), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .evt_valid_i(evt_valid_i),
        .evt_ready_o(evt_ready_o), .evt_data_i(evt_data_i), .req_o(req_o),
        .row_o(row_o), .col_o(col_o), .gnt_i(gnt_i), .busy_o(busy_o),
        .timeout_o(timeout_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction. gdly = REQ cycle index at which gnt_i rises (no grant if
    // gdly >= TIMEOUT); ghold = number of cycles gnt_i stays high.
    task automatic run_event(input logic pol, input logic [3:0] row, input logic [3:0] col,
                             input int gdly, input int ghold);
        logic [1:0] exp_req;
        bit         granted;
        int         nreq;
        int         k;
        int         w;
        exp_req = pol ? 2'b10 : 2'b01;
        granted = (gdly < TIMEOUT);
        nreq    = granted ? gdly + 1 : TIMEOUT;

        w = 0;
        while (!evt_ready_o && w < 20) begin
            step();
            w++;
        end
        check("ready_before_event", 32'(evt_ready_o), 32'd1);

        evt_valid_i = 1'b1;
        evt_data_i  = {pol, row, col};
        step();
        for (int c = 0; c < nreq; c++) begin
            check("req", 32'(req_o), 32'(exp_req));
            check("row", 32'(row_o), 32'(row));
            check("col", 32'(col_o), 32'(col));
            check("busy_req", 32'(busy_o), 32'd1);
            check("ready_req", 32'(evt_ready_o), 32'd0);
            check("timeout_req", 32'(timeout_o), 32'd0);
            // upstream noise while busy must be ignored
            evt_valid_i = 1'($urandom_range(0, 1));
            evt_data_i  = 9'($urandom);
            if (granted && c == gdly) gnt_i = 1'b1;
            step();
        end
        check("req_after", 32'(req_o), 32'd0);

        if (granted) begin
            k = gdly + 1;
            while (k < gdly + ghold) begin
                check("busy_release", 32'(busy_o), 32'd1);
                check("ready_release", 32'(evt_ready_o), 32'd0);
                check("timeout_release", 32'(timeout_o), 32'd0);
                step();
                k++;
            end
            gnt_i = 1'b0;
            check("busy_gnt_fall", 32'(busy_o), 32'd1);
            check("req_gnt_fall", 32'(req_o), 32'd0);
            step();
            evt_valid_i = 1'b0;
            check("idle_after_release", 32'(busy_o), 32'd0);
            check("ready_after_release", 32'(evt_ready_o), 32'd1);
            check("timeout_after_release", 32'(timeout_o), 32'd0);
            check("drop_after_grant", 32'(drop_cnt_o), 32'(drop_model));
        end else begin
            evt_valid_i = 1'b0;
            drop_model = (drop_model == MAXD) ? MAXD : drop_model + 1;
            check("timeout_pulse", 32'(timeout_o), 32'd1);
            check("drop_cnt", 32'(drop_cnt_o), 32'(drop_model));
            check("ready_after_drop", 32'(evt_ready_o), 32'd1);
            check("busy_after_drop", 32'(busy_o), 32'd0);
            step();
            check("timeout_single", 32'(timeout_o), 32'd0);
        end
    endtask

    initial begin
        reset_i     = 1'b0;
        evt_valid_i = 1'b1;
        evt_data_i  = 9'h1FF;
        gnt_i       = 1'b0;

        // reset with valid held high
        repeat (3) step();
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_ready", 32'(evt_ready_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_row", 32'(row_o), 32'd0);
        check("rst_col", 32'(col_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        evt_valid_i = 1'b0;
        reset_i     = 1'b1;
        step();
        check("ready_after_rst", 32'(evt_ready_o), 32'd1);

        run_event(1'b1, 4'h3, 4'h5, 3, 2);          // ON event, grant after 3 cycles
        run_event(1'b0, 4'hA, 4'h0, 1, 3);          // OFF event
        run_event(1'b1, 4'h7, 4'h2, 100, 0);        // timeout, drop 1
        run_event(1'b0, 4'h1, 4'hE, TIMEOUT - 1, 1); // grant on exact timeout cycle

        // grant while idle is ignored
        gnt_i = 1'b1;
        repeat (3) step();
        check("idle_gnt_busy", 32'(busy_o), 32'd0);
        check("idle_gnt_req", 32'(req_o), 32'd0);
        check("idle_gnt_drop", 32'(drop_cnt_o), 32'(drop_model));
        gnt_i = 1'b0;
        step();

        // four more drops: counter saturates at 3
        for (int i = 0; i < 4; i++) run_event(1'($urandom), 4'($urandom), 4'($urandom), 50, 0);

        for (int i = 0; i < 40; i++) begin
            run_event(1'($urandom), 4'($urandom), 4'($urandom),
                      int'($urandom_range(0, TIMEOUT + 3)), int'($urandom_range(1, 3)));
        end

        // reset in the middle of a request
        evt_valid_i = 1'b1;
        evt_data_i  = {1'b1, 4'h9, 4'h6};
        step();
        evt_valid_i = 1'b0;
        step();
        check("req_before_midrst", 32'(req_o), 32'd2);
        #2 reset_i = 1'b0;
        #1;
        check("midrst_req", 32'(req_o), 32'd0);
        check("midrst_drop", 32'(drop_cnt_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        drop_model = 0;
        repeat (2) step();
        reset_i = 1'b1;
        step();
        run_event(1'b0, 4'h4, 4'hB, 2, 1);
        run_event(1'b1, 4'hC, 4'hD, 30, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
